// File: rtl/vote_pkg.sv
// -----------------------------------------------------------------------------
// vote_pkg
//   Shared types and helpers for the vote tally collector.
//   - state_t   : collector FSM states (COLLECT -> DECIDE -> OUTPUT -> COLLECT)
//   - SAT       : saturation value of a counter at the default counter width
//   - onehot_ok : true when a ballot has exactly one bit set
// -----------------------------------------------------------------------------
package vote_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DECIDE  = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   // Widest ballot the helper below accepts; callers zero-extend into it.
   localparam int MAX_CAND = 32;

   // Default counter width and its saturation value. Blocks built with a
   // different CNT_W derive their own all-ones constant locally.
   localparam int                     DEF_CNT_W = 8;
   localparam logic [DEF_CNT_W-1:0]   SAT       = {DEF_CNT_W{1'b1}};

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   function automatic logic onehot_ok(input logic [MAX_CAND-1:0] vote);
      return (vote != '0) && ((vote & (vote - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/vote_sat_counter.sv
// -----------------------------------------------------------------------------
// vote_sat_counter
//   One saturating per-candidate ballot counter.
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   synchronous active-high reset
//     i_inc    in   count one ballot (ignored once the counter is at max)
//     i_clr    in   clear the count (takes priority over i_inc)
//     o_count  out  current count
//     o_at_max out  count equals the all-ones saturation value
// -----------------------------------------------------------------------------
module vote_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_count,
   output logic             o_at_max
);

   localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != CNT_SAT)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count  = r_count;
   assign o_at_max = (r_count == CNT_SAT);

endmodule

// File: rtl/vote_tally_collector.sv
// -----------------------------------------------------------------------------
// vote_tally_collector
//   Collects one-hot ballots into saturating per-candidate counters. A close
//   request starts a sequential argmax (one candidate per cycle); the packed
//   tally and winner are then held on a valid/ready result port until taken.
//   Ports:
//     clk, rst       clock (rising edge), synchronous active-high reset
//     ballot_valid   in   ballot present
//     ballot_ready   out  collector accepts ballots (COLLECT only)
//     ballot_vote    in   one-hot candidate choice, NUM_CAND bits
//     close_req      in   one-cycle pulse ending the election (COLLECT only)
//     busy           out  deciding or presenting a result
//     result_valid   out  result stable
//     result_ready   in   downstream takes the result
//     result_tally   out  packed counts, candidate i in [i*CNT_W +: CNT_W]
//     result_winner  out  lowest index holding the maximum count
//     result_tie     out  another candidate shares the maximum count
//     result_ovf     out  some counter saw a ballot while saturated
//     rejected_cnt   out  saturating count of non-one-hot ballots
// -----------------------------------------------------------------------------
module vote_tally_collector
   import vote_pkg::*;
#(
   parameter  int NUM_CAND = 3,
   parameter  int CNT_W    = 8,
   localparam int IDX_W    = $clog2(NUM_CAND)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ballot_valid,
   output logic                      ballot_ready,
   input  logic [NUM_CAND-1:0]       ballot_vote,
   input  logic                      close_req,
   output logic                      busy,
   output logic                      result_valid,
   input  logic                      result_ready,
   output logic [NUM_CAND*CNT_W-1:0] result_tally,
   output logic [IDX_W-1:0]          result_winner,
   output logic                      result_tie,
   output logic                      result_ovf,
   output logic [CNT_W-1:0]          rejected_cnt
);

   localparam logic [CNT_W-1:0] REJ_SAT  = {CNT_W{1'b1}};
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t                     r_state;
   logic                       r_ballot_ready;
   logic                       r_busy;
   logic                       r_ovf;          // sticky, cleared on handoff
   logic [CNT_W-1:0]           r_rejected;
   logic [IDX_W-1:0]           r_idx;          // candidate examined this cycle
   logic [IDX_W-1:0]           r_best;         // best index so far
   logic                       r_tie;          // best count is shared so far
   logic                       r_result_valid;
   logic [NUM_CAND*CNT_W-1:0]  r_result_tally;
   logic [IDX_W-1:0]           r_result_winner;
   logic                       r_result_tie;
   logic                       r_result_ovf;

   // ---------------------------------------------------------------------------
   // Ballot intake and counters
   // ---------------------------------------------------------------------------
   logic                       w_take;
   logic                       w_onehot;
   logic                       w_clr;
   logic [NUM_CAND-1:0]        w_inc;
   logic [NUM_CAND-1:0]        w_at_max;
   logic [CNT_W-1:0]           w_count [NUM_CAND];
   logic [NUM_CAND*CNT_W-1:0]  w_tally;

   // ballot_ready is only ever high in COLLECT, so it doubles as the
   // "collecting" qualifier for the handshake.
   assign w_take   = ballot_valid && r_ballot_ready;
   assign w_onehot = onehot_ok(MAX_CAND'(ballot_vote));
   assign w_clr    = (r_state == OUTPUT) && result_ready;

   for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_cand
      assign w_inc[gi]                   = w_take && w_onehot && ballot_vote[gi];
      assign w_tally[gi*CNT_W +: CNT_W]  = w_count[gi];

      vote_sat_counter #(
         .CNT_W   (CNT_W)
      ) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .i_inc    (w_inc[gi]),
         .i_clr    (w_clr),
         .o_count  (w_count[gi]),
         .o_at_max (w_at_max[gi])
      );
   end

   // An increment attempted on a saturated counter marks the election overflowed.
   logic w_sat_hit;
   assign w_sat_hit = |(w_inc & w_at_max);

   // ---------------------------------------------------------------------------
   // Argmax step: compare the candidate under examination with the best so far.
   // A strictly larger count takes over and drops the tie; an equal count keeps
   // the lower (earlier) index and flags the tie.
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] w_cur_cnt;
   logic [CNT_W-1:0] w_best_cnt;
   logic             w_gt;
   logic             w_eq;
   logic [IDX_W-1:0] w_best_next;
   logic             w_tie_next;
   logic             w_last;

   assign w_cur_cnt   = w_count[r_idx];
   assign w_best_cnt  = w_count[r_best];
   assign w_gt        = (w_cur_cnt > w_best_cnt);
   assign w_eq        = (w_cur_cnt == w_best_cnt);
   assign w_best_next = w_gt ? r_idx : r_best;
   assign w_tie_next  = w_gt ? 1'b0 : (w_eq ? 1'b1 : r_tie);
   assign w_last      = (r_idx == LAST_IDX);

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= COLLECT;
         r_ballot_ready  <= 1'b1;
         r_busy          <= 1'b0;
         r_ovf           <= 1'b0;
         r_rejected      <= '0;
         r_idx           <= '0;
         r_best          <= '0;
         r_tie           <= 1'b0;
         r_result_valid  <= 1'b0;
         r_result_tally  <= '0;
         r_result_winner <= '0;
         r_result_tie    <= 1'b0;
         r_result_ovf    <= 1'b0;
      end else begin
         case (r_state)
            COLLECT: begin
               if (w_take && !w_onehot && (r_rejected != REJ_SAT)) begin
                  r_rejected <= r_rejected + 1'b1;
               end
               if (w_sat_hit) begin
                  r_ovf <= 1'b1;
               end
               // A ballot in the close cycle lands in the counters on this same
               // edge, so the first DECIDE cycle already sees it.
               if (close_req) begin
                  r_state        <= DECIDE;
                  r_ballot_ready <= 1'b0;
                  r_busy         <= 1'b1;
                  r_idx          <= IDX_W'(1);
                  r_best         <= '0;
                  r_tie          <= 1'b0;
               end
            end

            DECIDE: begin
               r_best <= w_best_next;
               r_tie  <= w_tie_next;
               r_idx  <= r_idx + 1'b1;
               // The final comparison feeds the result registers directly so
               // OUTPUT is entered NUM_CAND-1 cycles after the close.
               if (w_last) begin
                  r_state         <= OUTPUT;
                  r_result_valid  <= 1'b1;
                  r_result_tally  <= w_tally;
                  r_result_winner <= w_best_next;
                  r_result_tie    <= w_tie_next;
                  r_result_ovf    <= r_ovf;
               end
            end

            OUTPUT: begin
               if (result_ready) begin
                  r_state         <= COLLECT;
                  r_ballot_ready  <= 1'b1;
                  r_busy          <= 1'b0;
                  r_ovf           <= 1'b0;
                  r_rejected      <= '0;
                  r_result_valid  <= 1'b0;
                  r_result_tally  <= '0;
                  r_result_winner <= '0;
                  r_result_tie    <= 1'b0;
                  r_result_ovf    <= 1'b0;
               end
            end

            default: begin
               r_state        <= COLLECT;
               r_ballot_ready <= 1'b1;
               r_busy         <= 1'b0;
               r_result_valid <= 1'b0;
            end
         endcase
      end
   end

   assign ballot_ready  = r_ballot_ready;
   assign busy          = r_busy;
   assign result_valid  = r_result_valid;
   assign result_tally  = r_result_tally;
   assign result_winner = r_result_winner;
   assign result_tie    = r_result_tie;
   assign result_ovf    = r_result_ovf;
   assign rejected_cnt  = r_rejected;

endmodule

// File: tb/tb_vote_tally_collector.sv
// -----------------------------------------------------------------------------
// tb_vote_tally_collector
//   Self-checking bench: table of elections, hand-written multi-cycle corner
//   cases, a CNT_W=4 saturation instance and randomized elections checked
//   against a counting model.
// -----------------------------------------------------------------------------
module tb_vote_tally_collector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (NUM_CAND=3, CNT_W=8)
   logic        rst;
   logic        ballot_valid;
   logic        ballot_ready;
   logic [2:0]  ballot_vote;
   logic        close_req;
   logic        busy;
   logic        result_valid;
   logic        result_ready;
   logic [23:0] result_tally;
   logic [1:0]  result_winner;
   logic        result_tie;
   logic        result_ovf;
   logic [7:0]  rejected_cnt;

   // Narrow instance (NUM_CAND=3, CNT_W=4)
   logic        bv4, br4, cr4, busy4, rv4, rr4, tie4, ovf4;
   logic [2:0]  vote4;
   logic [11:0] tally4;
   logic [1:0]  win4;
   logic [3:0]  rej4;

   vote_tally_collector #(.NUM_CAND(3), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .ballot_valid(ballot_valid), .ballot_ready(ballot_ready), .ballot_vote(ballot_vote),
      .close_req(close_req), .busy(busy),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_tally(result_tally), .result_winner(result_winner),
      .result_tie(result_tie), .result_ovf(result_ovf), .rejected_cnt(rejected_cnt)
   );

   vote_tally_collector #(.NUM_CAND(3), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .ballot_valid(bv4), .ballot_ready(br4), .ballot_vote(vote4),
      .close_req(cr4), .busy(busy4),
      .result_valid(rv4), .result_ready(rr4),
      .result_tally(tally4), .result_winner(win4),
      .result_tie(tie4), .result_ovf(ovf4), .rejected_cnt(rej4)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: plain per-candidate counts, argmax by scanning
   // ---------------------------------------------------------------------------
   int m_cnt[3];
   int m_rej;
   bit m_ovf;

   task automatic m_clear();
      for (int k = 0; k < 3; k++) m_cnt[k] = 0;
      m_rej = 0;
      m_ovf = 0;
   endtask

   task automatic m_ballot(input logic [2:0] v);
      if ($countones(v) == 1) begin
         for (int k = 0; k < 3; k++) begin
            if (v[k]) begin
               if (m_cnt[k] == 255) m_ovf = 1;
               else                 m_cnt[k]++;
            end
         end
      end else if (m_rej < 255) begin
         m_rej++;
      end
   endtask

   task automatic m_expect(output logic [23:0] tally, output logic [1:0] win, output logic tie);
      int mx, nmax, w;
      mx = 0;
      for (int k = 0; k < 3; k++) if (m_cnt[k] > mx) mx = m_cnt[k];
      nmax = 0;
      w = -1;
      for (int k = 0; k < 3; k++) begin
         if (m_cnt[k] == mx) begin
            nmax++;
            if (w < 0) w = k;
         end
      end
      tally = {8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
      win   = 2'(w);
      tie   = (nmax > 1);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus helpers (inputs driven 1 time unit after the rising edge)
   // ---------------------------------------------------------------------------
   task automatic send(input logic [2:0] v);
      chk("ballot_ready_collect", ballot_ready, 1'b1);
      ballot_valid = 1'b1;
      ballot_vote  = v;
      @(posedge clk); #1;
      ballot_valid = 1'b0;
   endtask

   // Close the election and check the result. Optionally: a ballot in the
   // close cycle, a close+ballot pulse during DECIDE, and a hold of
   // result_ready low with ballot/close noise applied.
   task automatic close_and_check(input string tag, input bit with_ballot, input logic [2:0] v,
                                  input int hold, input bit decide_noise,
                                  input logic [23:0] e_tally, input logic [7:0] e_rej,
                                  input logic [1:0] e_win, input logic e_tie, input logic e_ovf);
      int cyc;
      close_req = 1'b1;
      if (with_ballot) begin
         ballot_valid = 1'b1;
         ballot_vote  = v;
      end
      @(posedge clk); #1;
      close_req    = 1'b0;
      ballot_valid = 1'b0;
      cyc = 0;
      while (!result_valid && cyc < 20) begin
         if (decide_noise && cyc == 0) begin
            chk({tag, "_busy_decide"}, busy, 1'b1);
            close_req    = 1'b1;
            ballot_valid = 1'b1;
            ballot_vote  = 3'b001;
         end
         @(posedge clk); #1;
         close_req    = 1'b0;
         ballot_valid = 1'b0;
         cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'd2);
      chk({tag, "_tally"},  result_tally,  e_tally);
      chk({tag, "_winner"}, result_winner, e_win);
      chk({tag, "_tie"},    result_tie,    e_tie);
      chk({tag, "_ovf"},    result_ovf,    e_ovf);
      chk({tag, "_rej"},    rejected_cnt,  e_rej);
      chk({tag, "_busy"},   busy,          1'b1);
      chk({tag, "_bready_out"}, ballot_ready, 1'b0);
      for (int h = 0; h < hold; h++) begin
         ballot_valid = 1'b1;
         ballot_vote  = 3'(1 << (h % 3));
         close_req    = (h % 2 == 0);
         @(posedge clk); #1;
         chk({tag, "_hold_valid"},  result_valid, 1'b1);
         chk({tag, "_hold_tally"},  result_tally, e_tally);
         chk({tag, "_hold_winner"}, {result_winner, result_tie, result_ovf}, {e_win, e_tie, e_ovf});
         chk({tag, "_hold_bready"}, ballot_ready, 1'b0);
      end
      ballot_valid = 1'b0;
      close_req    = 1'b0;
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      chk({tag, "_after_valid"},  result_valid, 1'b0);
      chk({tag, "_after_bready"}, ballot_ready, 1'b1);
      chk({tag, "_after_busy"},   busy,         1'b0);
      chk({tag, "_after_rej"},    rejected_cnt, 8'd0);
      $display("election %s: tally=%h winner=%0d tie=%0d ovf=%0d rej=%0d latency=%0d",
               tag, e_tally, e_win, e_tie, e_ovf, e_rej, cyc);
   endtask

   // ---------------------------------------------------------------------------
   // Election table: ballot k sits in ballots[k*3 +: 3]
   // ---------------------------------------------------------------------------
   typedef struct {
      int          n;
      logic [23:0] ballots;
      logic [7:0]  c0, c1, c2;
      logic [7:0]  rej;
      logic [1:0]  win;
      logic        tie;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [23:0] e_tally;
      logic [1:0]  e_win;
      logic        e_tie;
      int          cyc;

      vecs[0] = '{n:5, ballots:{9'b0, 3'b010, 3'b100, 3'b010, 3'b010, 3'b001},
                  c0:8'd1, c1:8'd3, c2:8'd1, rej:8'd0, win:2'd1, tie:1'b0};
      vecs[1] = '{n:4, ballots:{12'b0, 3'b001, 3'b111, 3'b011, 3'b000},
                  c0:8'd1, c1:8'd0, c2:8'd0, rej:8'd3, win:2'd0, tie:1'b0};
      vecs[2] = '{n:4, ballots:{12'b0, 3'b100, 3'b100, 3'b001, 3'b001},
                  c0:8'd2, c1:8'd0, c2:8'd2, rej:8'd0, win:2'd0, tie:1'b1};
      vecs[3] = '{n:0, ballots:24'b0,
                  c0:8'd0, c1:8'd0, c2:8'd0, rej:8'd0, win:2'd0, tie:1'b1};
      vecs[4] = '{n:3, ballots:{15'b0, 3'b010, 3'b100, 3'b100},
                  c0:8'd0, c1:8'd1, c2:8'd2, rej:8'd0, win:2'd2, tie:1'b0};
      vecs[5] = '{n:4, ballots:{12'b0, 3'b100, 3'b010, 3'b100, 3'b010},
                  c0:8'd0, c1:8'd2, c2:8'd2, rej:8'd0, win:2'd1, tie:1'b1};
      vecs[6] = '{n:2, ballots:{18'b0, 3'b101, 3'b110},
                  c0:8'd0, c1:8'd0, c2:8'd0, rej:8'd2, win:2'd0, tie:1'b1};

      rst = 1'b1;
      ballot_valid = 1'b0; ballot_vote = 3'b0; close_req = 1'b0; result_ready = 1'b0;
      bv4 = 1'b0; vote4 = 3'b0; cr4 = 1'b0; rr4 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      chk("rst_bready", ballot_ready, 1'b1);
      chk("rst_busy",   busy,         1'b0);
      chk("rst_valid",  result_valid, 1'b0);
      chk("rst_result", {result_tally, result_winner, result_tie, result_ovf}, 28'd0);
      chk("rst_rej",    rejected_cnt, 8'd0);

      // Table-driven elections; the first one also holds result_ready low
      // for 10 cycles with ballot/close noise.
      for (int i = 0; i < 7; i++) begin
         for (int k = 0; k < vecs[i].n; k++) send(vecs[i].ballots[k*3 +: 3]);
         close_and_check($sformatf("table%0d", i), 1'b0, 3'b0, (i == 0) ? 10 : 0, 1'b0,
                         {vecs[i].c2, vecs[i].c1, vecs[i].c0}, vecs[i].rej,
                         vecs[i].win, vecs[i].tie, 1'b0);
      end

      // Ballot in the close cycle counts; close+ballot during DECIDE ignored.
      send(3'b010);
      close_and_check("close_with_ballot", 1'b1, 3'b100, 0, 1'b1,
                      {8'd1, 8'd1, 8'd0}, 8'd0, 2'd1, 1'b1, 1'b0);

      // Reset in the middle of DECIDE aborts the election.
      send(3'b001); send(3'b001); send(3'b000);
      close_req = 1'b1;
      @(posedge clk); #1;
      close_req = 1'b0;
      chk("mid_decide_busy", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_valid",  result_valid, 1'b0);
      chk("abort_bready", ballot_ready, 1'b1);
      chk("abort_busy",   busy,         1'b0);
      chk("abort_rej",    rejected_cnt, 8'd0);
      close_and_check("after_abort", 1'b0, 3'b0, 0, 1'b0, 24'd0, 8'd0, 2'd0, 1'b1, 1'b0);

      // CNT_W=4 saturation: 20 ballots for candidate 2.
      for (int k = 0; k < 20; k++) begin
         chk("sat_bready", br4, 1'b1);
         bv4 = 1'b1; vote4 = 3'b100;
         @(posedge clk); #1;
         bv4 = 1'b0;
      end
      cr4 = 1'b1;
      @(posedge clk); #1;
      cr4 = 1'b0;
      cyc = 0;
      while (!rv4 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("sat_latency", 64'(cyc), 64'd2);
      chk("sat_tally",   tally4, {4'd15, 4'd0, 4'd0});
      chk("sat_ovf",     ovf4,   1'b1);
      chk("sat_winner",  win4,   2'd2);
      chk("sat_tie",     tie4,   1'b0);
      chk("sat_rej",     rej4,   4'd0);
      $display("election sat4: tally=%h winner=%0d ovf=%0d", tally4, win4, ovf4);
      rr4 = 1'b1;
      @(posedge clk); #1;
      rr4 = 1'b0;
      cr4 = 1'b1;
      @(posedge clk); #1;
      cr4 = 1'b0;
      cyc = 0;
      while (!rv4 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("sat_cleared", {tally4, ovf4}, 13'd0);
      rr4 = 1'b1;
      @(posedge clk); #1;
      rr4 = 1'b0;

      // Randomized elections against the model.
      m_clear();
      for (int e = 0; e < 25; e++) begin
         int          nb;
         bit          wb;
         logic [2:0]  v;
         logic [2:0]  lv;
         nb = $urandom_range(0, 30);
         for (int k = 0; k < nb; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) v = 3'($urandom_range(0, 7));
            else                           v = 3'(1 << $urandom_range(0, 2));
            m_ballot(v);
            send(v);
         end
         wb = 1'($urandom_range(0, 1));
         lv = 3'($urandom_range(0, 7));
         if (wb) m_ballot(lv);
         m_expect(e_tally, e_win, e_tie);
         close_and_check($sformatf("rand%0d", e), wb, lv, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                         e_tally, 8'(m_rej), e_win, e_tie, m_ovf);
         m_clear();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
